regfile_dumper: RTL and testbench
=================================

# regfile_dumper

Debug read-out engine that walks a range of the 32-entry CPU register file through a spare combinational read port and streams each register's contents out over a valid/ready handshake. It is started by a one-cycle `start` pulse and sits beside the register file in the single-cycle CPU, acting as its reader toward a debug UART, trace buffer or testbench monitor. It never writes the register file.

## Interface
- `NREGS`, 32, number of registers addressed; must be a power of two.
- `AW`, 5, register address width, equal to log2(`NREGS`).
- `DW`, 32, register data width.

- `clk`  in  1  clock; all state updates on its rising edge.
- `myreset`  in  1  reset; synchronous and active-high.
- `start`  in  1  begin a dump; sampled only in IDLE.
- `first_reg`  in  AW  first register index; sampled with `start`.
- `last_reg`  in  AW  last register index, inclusive; sampled with `start`.
- `rd_addr`  out  AW  address driven to the register file's spare read port.
- `rd_data`  in  DW  combinational read data returned from `rd_addr` in the same cycle.
- `out_valid`  out  1  `out_data`, `out_addr` and `out_last` are valid.
- `out_ready`  in  1  consumer accepts the word; a transfer happens when `out_valid` and `out_ready` are both 1.
- `out_data`  out  DW  register contents.
- `out_addr`  out  AW  index of the register in `out_data`.
- `out_last`  out  1  marks the final word of the dump.
- `busy`  out  1  high in FETCH, SEND and CKSUM.
- `done`  out  1  one-cycle pulse after the final transfer.

## Operation
- **States:** IDLE, FETCH, SEND, CKSUM, DONE.
- **IDLE:**
  - `rd_addr` = 0.
  - On `start`=1: latch `first_reg` into `cur` and `last_reg` into `end`, then go to FETCH.
- **FETCH:**
  - `rd_addr` = `cur`.
  - At the clock edge: `out_data` <= `rd_data`; `out_addr` <= `cur`; `out_last` <= (`cur`==`end`), forced to 0 when `REGDUMP_CHECKSUM_EN` is defined.
  - Go to SEND.
- **SEND:**
  - `out_valid`=1.
  - `out_data`, `out_addr` and `out_last` stay stable until the transfer.
  - On transfer, if `cur`==`end`: go to CKSUM when the macro is defined, otherwise go to DONE.
  - On transfer, if `cur`!=`end`: `cur` <= `cur`+1 modulo `NREGS`, then go to FETCH.
- **CKSUM (macro only):**
  - `out_valid`=1; `out_data` = checksum; `out_addr` = 0; `out_last` = 1.
  - On transfer, go to DONE.
- **DONE:** `done`=1 and `busy`=0; go to IDLE on the next cycle.
- **Address wrap:** if `first_reg` > `last_reg`, the walk wraps from 31 to 0. `first_reg`==`last_reg` dumps exactly one word.
- **`start` while not in IDLE:** ignored, including during DONE.
- **Reset:** `myreset`=1 aborts any dump at the next edge and returns to IDLE with all outputs 0. No partial word stays valid.
- **No snapshot atomicity:** each register is read in its own FETCH cycle, so a CPU write landing between fetches is visible for registers not yet fetched.
- **Register 0:** emitted like any other register; it reads 0 in the register file.

## Timing
- **Reset values:** `rd_addr`=0, `out_valid`=0, `out_data`=0, `out_addr`=0, `out_last`=0, `busy`=0, `done`=0.
- **Start latency:** `start` sampled at edge E0 → FETCH during E0..E1 → `out_valid`=1 from E1. That is 1 cycle from `start` to valid.
- **Throughput:** 2 cycles per word with `out_ready` held high (FETCH, then SEND).
- **Dump length:** N = ((`last_reg`−`first_reg`) mod 32)+1 registers take 1+2N cycles from `start` to `done`, plus 1 cycle for the checksum when the macro is defined. `out_ready` stalls add directly to this.
- **Completion:** `done` rises the cycle after the final transfer. `busy` falls in the same cycle.
- **Output registering:** all outputs are registered except `rd_addr`, which is decoded from the state and `cur`.

## Configuration
- **`REGDUMP_CHECKSUM_EN` defined:**
  - A 32-bit XOR of every emitted `out_data` word is accumulated; the accumulator is cleared when `start` is accepted.
  - The checksum is appended as a final word with `out_addr`=0 and `out_last`=1.
  - Register words all have `out_last`=0.
- **Macro undefined:**
  - The CKSUM state and the accumulator are absent.
  - `out_last`=1 on the last register word.

## Test plan
- **Full dump:** preload Rk = k·0x11; `first_reg`=0, `last_reg`=31, `out_ready`=1 → 32 words in address order, data k·0x11. `out_last` only on address 31 (macro off). `done` at cycle 65 after `start`.
- **Backpressure:** `first_reg`=`last_reg`=2, R2=0xDEADBEEF, `out_ready` low for 5 cycles → `out_valid` stays high and `out_data` holds 0xDEADBEEF. Transfer on the first cycle `out_ready`=1; `done` the next cycle.
- **Wrap:** `first_reg`=30, `last_reg`=1 → `out_addr` sequence 30, 31, 0, 1, with `out_last` on 1.
- **Reset mid-dump:** assert `myreset` during the 3rd SEND → next cycle `out_valid`=0, `busy`=0, `done`=0. A new `start` then dumps from `first_reg` again.
- **Start while busy:** pulse `start` with a different range during a dump → ignored; the original range completes unchanged.
- **Checksum (macro on):** R3=0x0000FFFF, R4=0xFFFF0000, range 3..4 → three words: 0x0000FFFF, 0xFFFF0000, then 0xFFFFFFFF with `out_addr`=0 and `out_last`=1.

Source files
------------

// File: rtl/regfile_dumper_if.sv
// regfile_dumper_if: start/range, register-file read port and output stream of the register dumper
interface regfile_dumper_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          i_start;
    logic [AW-1:0] i_first_reg;
    logic [AW-1:0] i_last_reg;
    logic [AW-1:0] o_rd_addr;
    logic [DW-1:0] i_rd_data;
    logic          o_out_valid;
    logic          i_out_ready;
    logic [DW-1:0] o_out_data;
    logic [AW-1:0] o_out_addr;
    logic          o_out_last;
    logic          o_busy;
    logic          o_done;

    modport slave (
        input  i_start, i_first_reg, i_last_reg, i_rd_data, i_out_ready,
        output o_rd_addr, o_out_valid, o_out_data, o_out_addr, o_out_last, o_busy, o_done
    );

    modport master (
        output i_start, i_first_reg, i_last_reg, i_rd_data, i_out_ready,
        input  o_rd_addr, o_out_valid, o_out_data, o_out_addr, o_out_last, o_busy, o_done
    );
endinterface

// File: rtl/regfile_dumper.sv
// regfile_dumper: walks a register range and streams each word out; REGDUMP_CHECKSUM_EN appends an XOR checksum word
module regfile_dumper #(
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic           clk,
    input  logic           myreset,
    regfile_dumper_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_SEND  = 3'd2;
`ifdef REGDUMP_CHECKSUM_EN
    localparam logic [2:0] S_CKSUM = 3'd3;
`endif
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]    r_state;
    logic [AW-1:0] r_cur;
    logic [AW-1:0] r_end;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic          r_valid;
    logic          r_last;
    logic          r_busy;
    logic          r_done;
`ifdef REGDUMP_CHECKSUM_EN
    logic [DW-1:0] r_sum;
`endif
    logic          w_at_end;
    logic [AW-1:0] w_next;

    assign w_at_end = (r_cur == r_end);
    assign w_next   = (r_cur == AW'(NREGS - 1)) ? '0 : r_cur + 1'b1;

    assign bus.o_rd_addr   = (r_state == S_FETCH) ? r_cur : '0;
    assign bus.o_out_valid = r_valid;
    assign bus.o_out_data  = r_data;
    assign bus.o_out_addr  = r_addr;
    assign bus.o_out_last  = r_last;
    assign bus.o_busy      = r_busy;
    assign bus.o_done      = r_done;

    // Dump sequencer: one fetch cycle per register, then hold the word until the consumer takes it
    always_ff @(posedge clk) begin
        if (myreset) begin
            r_state <= S_IDLE;
            r_cur   <= '0;
            r_end   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            r_sum   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (bus.i_start) begin
                    r_cur   <= bus.i_first_reg;
                    r_end   <= bus.i_last_reg;
                    r_busy  <= 1'b1;
                    r_state <= S_FETCH;
`ifdef REGDUMP_CHECKSUM_EN
                    r_sum   <= '0;
`endif
                end
                S_FETCH: begin
                    r_data  <= bus.i_rd_data;
                    r_addr  <= r_cur;
                    r_valid <= 1'b1;
                    r_state <= S_SEND;
`ifdef REGDUMP_CHECKSUM_EN
                    r_last  <= 1'b0;
                    r_sum   <= r_sum ^ bus.i_rd_data;
`else
                    r_last  <= w_at_end;
`endif
                end
                S_SEND: if (bus.i_out_ready) begin
                    if (w_at_end) begin
`ifdef REGDUMP_CHECKSUM_EN
                        r_data  <= r_sum;
                        r_addr  <= '0;
                        r_last  <= 1'b1;
                        r_state <= S_CKSUM;
`else
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
`endif
                    end else begin
                        r_cur   <= w_next;
                        r_valid <= 1'b0;
                        r_state <= S_FETCH;
                    end
                end
`ifdef REGDUMP_CHECKSUM_EN
                S_CKSUM: if (bus.i_out_ready) begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
`endif
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_dumper.sv
// tb_regfile_dumper: directed dumps against a queue model of the expected word stream
module tb_regfile_dumper;
`ifdef REGDUMP_CHECKSUM_EN
    localparam int CKS = 1;
`else
    localparam int CKS = 0;
`endif

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic        l;
    } word_t;

    logic        clk = 1'b0;
    logic        myreset = 1'b1;
    logic [31:0] regs [32];
    word_t       exp_q [$];
    word_t       obs [$];
    logic        m_active = 1'b0;
    logic        m_done = 1'b0;
    logic        chk_en = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc;

    regfile_dumper_if #(.AW(5), .DW(32)) bus ();

    regfile_dumper #(.NREGS(32), .AW(5), .DW(32)) dut (
        .clk(clk),
        .myreset(myreset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    assign bus.i_rd_data = regs[bus.o_rd_addr];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected stream: registers first..last walking modulo 32, then the checksum word when enabled
    task automatic push_model(input logic [4:0] f, input logic [4:0] l);
        int n = int'(5'(l - f)) + 1;
        logic [31:0] x = '0;
        logic [4:0] a;
        for (int i = 0; i < n; i++) begin
            a = f + 5'(i);
            exp_q.push_back('{a, regs[a], (CKS == 0) && (i == n - 1)});
            x ^= regs[a];
        end
        if (CKS != 0) exp_q.push_back('{5'd0, x, 1'b1});
    endtask

    task automatic launch(input logic [4:0] f, input logic [4:0] l);
        @(posedge clk);
        #1;
        bus.i_start = 1'b1;
        bus.i_first_reg = f;
        bus.i_last_reg = l;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        obs.delete();
        push_model(f, l);
        m_active = 1'b1;
    endtask

    task automatic dump(input logic [4:0] f, input logic [4:0] l, input int stall, input int poke, output int c);
        int n = int'(5'(l - f)) + 1;
        int exp_c = 1 + 2 * n + stall + CKS;
        c = 1;
        bus.i_out_ready = (stall == 0);
        launch(f, l);
        while (c < exp_c + 20) begin
            @(negedge clk);
            if (stall > 0 && c >= 2 && c <= 1 + stall) begin
                check("bp_valid", bus.o_out_valid, 1);
                check("bp_data", bus.o_out_data, regs[f]);
            end
            if (bus.o_done) break;
            @(posedge clk);
            c++;
            #1;
            bus.i_out_ready = (stall == 0) || (c >= 2 + stall);
            if (poke != 0 && c == poke) begin
                bus.i_start = 1'b1;
                bus.i_first_reg = f + 5'd7;
                bus.i_last_reg = f + 5'd9;
            end else begin
                bus.i_start = 1'b0;
                bus.i_first_reg = f;
                bus.i_last_reg = l;
            end
        end
        check("latency", c, exp_c);
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        bus.i_out_ready = 1'b1;
    endtask

    // Per-cycle comparison of busy/done/stream against the model
    initial forever begin
        @(negedge clk);
        if (chk_en && !myreset) begin
            check("busy", bus.o_busy, m_active);
            check("done", bus.o_done, m_done);
            m_done = 1'b0;
            if (bus.o_out_valid) begin
                if (exp_q.size() == 0) check("spurious_valid", 1, 0);
                else begin
                    check("out_data", bus.o_out_data, exp_q[0].d);
                    check("out_addr", bus.o_out_addr, exp_q[0].a);
                    check("out_last", bus.o_out_last, exp_q[0].l);
                    if (bus.i_out_ready) begin
                        obs.push_back('{bus.o_out_addr, bus.o_out_data, bus.o_out_last});
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) begin
                            m_active = 1'b0;
                            m_done = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.i_start = 1'b0;
        bus.i_first_reg = '0;
        bus.i_last_reg = '0;
        bus.i_out_ready = 1'b1;
        for (int k = 0; k < 32; k++) regs[k] = 32'(k) * 32'h11;
        repeat (3) @(posedge clk);
        #1;
        myreset = 1'b0;
        @(negedge clk);
        check("rst_valid", bus.o_out_valid, 0);
        check("rst_data", bus.o_out_data, 0);
        check("rst_addr", bus.o_out_addr, 0);
        check("rst_last", bus.o_out_last, 0);
        check("rst_busy", bus.o_busy, 0);
        check("rst_done", bus.o_done, 0);
        check("rst_rd_addr", bus.o_rd_addr, 0);
        chk_en = 1'b1;

        dump(5'd0, 5'd31, 0, 0, cyc);
        check("full_cycles", cyc, 65 + CKS);
        check("full_count", obs.size(), 32 + CKS);
        check("full_r0", obs[0].d, 32'h0);
        check("full_a31", obs[31].a, 31);
        check("full_d31", obs[31].d, 32'h20F);
        check("full_l31", obs[31].l, (CKS == 0));
        check("full_l30", obs[30].l, 0);

        regs[2] = 32'hDEADBEEF;
        dump(5'd2, 5'd2, 5, 0, cyc);
        check("bp_cycles", cyc, 8 + CKS);
        check("bp_word", obs[0].d, 32'hDEADBEEF);

        dump(5'd30, 5'd1, 0, 0, cyc);
        check("wrap_a0", obs[0].a, 30);
        check("wrap_a1", obs[1].a, 31);
        check("wrap_a2", obs[2].a, 0);
        check("wrap_a3", obs[3].a, 1);
        check("wrap_l3", obs[3].l, (CKS == 0));
        check("wrap_l2", obs[2].l, 0);

        bus.i_out_ready = 1'b1;
        launch(5'd5, 5'd12);
        repeat (5) @(posedge clk);
        #1;
        myreset = 1'b1;
        @(posedge clk);
        #1;
        myreset = 1'b0;
        exp_q.delete();
        m_active = 1'b0;
        m_done = 1'b0;
        @(negedge clk);
        check("abort_valid", bus.o_out_valid, 0);
        check("abort_busy", bus.o_busy, 0);
        check("abort_done", bus.o_done, 0);
        check("abort_data", bus.o_out_data, 0);
        check("abort_last", bus.o_out_last, 0);
        check("abort_words", obs.size(), 2);
        dump(5'd5, 5'd12, 0, 0, cyc);
        check("restart_first", obs[0].a, 5);
        check("restart_count", obs.size(), 8 + CKS);

        dump(5'd10, 5'd14, 0, 4, cyc);
        check("poke_busy_first", obs[0].a, 10);
        check("poke_busy_last", obs[4].a, 14);
        dump(5'd10, 5'd14, 0, 11 + CKS, cyc);
        check("poke_done_count", obs.size(), 5 + CKS);
        repeat (3) @(posedge clk);

        regs[3] = 32'h0000FFFF;
        regs[4] = 32'hFFFF0000;
        dump(5'd3, 5'd4, 0, 0, cyc);
        check("ck_w0", obs[0].d, 32'h0000FFFF);
        check("ck_w1", obs[1].d, 32'hFFFF0000);
`ifdef REGDUMP_CHECKSUM_EN
        check("ck_count", obs.size(), 3);
        check("ck_sum", obs[2].d, 32'hFFFFFFFF);
        check("ck_addr", obs[2].a, 0);
        check("ck_last", obs[2].l, 1);
        check("ck_l1", obs[1].l, 0);
`else
        check("ck_count", obs.size(), 2);
        check("ck_l1", obs[1].l, 1);
`endif
        @(negedge clk);
        check("end_queue", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
